// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready bus of one pipeline stage register
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96
);
  logic in_valid;
  logic in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage register with stall, flush and saturating flush counter
// Defining PIPE_STAGE_SKID_EN adds a one-entry skid buffer so in_ready no longer depends on out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  output logic [CNT_W-1:0] flush_cnt,
  pipe_stage_reg_if.slave p
);
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
`else
  typedef enum logic {EMPTY, FULL} state_t;
`endif
  state_t state, nextState;
  logic [CTRL_W-1:0] outCtrl;
  logic [DATA_W-1:0] outData;
  logic space, accept, drain;
  logic [1:0] held;
  logic [CNT_W:0] cntSum;
  assign drain = (state != EMPTY) && p.out_ready;
`ifdef PIPE_STAGE_SKID_EN
  assign space = state != SKID;
  assign held = 2'(state != EMPTY && !drain) + 2'(state == SKID);
`else
  assign space = (state == EMPTY) || p.out_ready;
  assign held = {1'b0, state != EMPTY && !drain};
`endif
  assign p.in_ready = rst && !flush && !stall && space;
  assign accept = p.in_valid && p.in_ready;
  assign cntSum = {1'b0, flush_cnt} + (CNT_W+1)'(held);
  assign p.out_valid = state != EMPTY;
  assign p.out_ctrl = outCtrl;
  assign p.out_data = outData;
  always_ff @(posedge clk)
    if (!rst) state <= EMPTY;
    else state <= nextState;
  always_comb begin
    nextState = state;
    if (flush) nextState = EMPTY;
    else if (state == EMPTY) nextState = accept ? FULL : EMPTY;
`ifdef PIPE_STAGE_SKID_EN
    else if (state == FULL) nextState = (accept && !drain) ? SKID : (drain && !accept) ? EMPTY : FULL;
    else nextState = drain ? FULL : SKID;
`else
    else nextState = (drain && !accept) ? EMPTY : FULL;
`endif
  end
  // the output slot reloads whenever it is empty or its entry leaves this cycle
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      outCtrl <= '0;
      outData <= '0;
    end else if (state == EMPTY || drain) begin
`ifdef PIPE_STAGE_SKID_EN
      if (state == SKID) begin
        outCtrl <= skidCtrl;
        outData <= skidData;
      end else
`endif
      if (accept) begin
        outCtrl <= p.in_ctrl;
        outData <= p.in_data;
      end else outCtrl <= '0;
    end
`ifdef PIPE_STAGE_SKID_EN
    if (accept && state == FULL && !drain) begin
      skidCtrl <= p.in_ctrl;
      skidData <= p.in_data;
    end
`endif
    if (!rst) flush_cnt <= '0;
    else if (flush) flush_cnt <= cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
  end
endmodule
